// File: rtl/seq_mul_hs_if.sv
// Operand/product handshake bundle between a producer/consumer pair and seq_mul_hs.
interface seq_mul_hs_if #(
  parameter int unsigned A_W = 8,
  parameter int unsigned B_W = 8,
  parameter int unsigned P_W = A_W + B_W
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] product;
  logic           overflow;
  logic           busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, overflow, busy
  );
endinterface

// File: rtl/seq_mul_hs.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, valid/ready on both sides.
// Signed mode multiplies magnitudes and restores the sign at the end.
module seq_mul_hs #(
  parameter int unsigned A_W    = 8,
  parameter int unsigned B_W    = 8,
  parameter int unsigned P_W    = A_W + B_W,
  parameter bit          SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mul_hs_if.slave  bus
);
  localparam int unsigned N_W  = A_W + B_W;
  localparam int unsigned F_W  = (P_W > N_W) ? P_W : N_W;
  localparam int unsigned CW   = $clog2(B_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic           accept, finish;
  logic [CW-1:0]  cnt_q;
  logic [N_W-1:0] mcand_q, acc_q, acc_sum, res;
  logic [B_W-1:0] mplier_q;
  logic           neg_q;
  logic [A_W-1:0] a_mag;
  logic [B_W-1:0] b_mag;
  logic           neg_in;
  logic [F_W-1:0] res_ext, re_ext;
  logic [P_W-1:0] trunc;
  logic           ovf;

  logic           in_ready_q, out_valid_q, busy_q, overflow_q;
  logic [P_W-1:0] product_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = CALC;
      end
      CALC: if (cnt_q == CW'(B_W - 1)) begin
        finish  = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes and result sign at capture; most-negative values fit as unsigned
  always_comb begin
    a_mag  = (SIGNED && bus.a[A_W-1]) ? A_W'(-bus.a) : bus.a;
    b_mag  = (SIGNED && bus.b[B_W-1]) ? B_W'(-bus.b) : bus.b;
    neg_in = SIGNED && (bus.a[A_W-1] ^ bus.b[B_W-1]);
  end

  // Final accumulate, sign restore, truncation and overflow detection
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    res     = (neg_q && (acc_sum != '0)) ? N_W'(-acc_sum) : acc_sum;
    if (SIGNED) res_ext = F_W'($signed(res));
    else        res_ext = F_W'(res);
    trunc = res_ext[P_W-1:0];
    if (SIGNED) re_ext = F_W'($signed(trunc));
    else        re_ext = F_W'(trunc);
    ovf = (re_ext != res_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        mcand_q  <= N_W'(a_mag);
        mplier_q <= b_mag;
        acc_q    <= '0;
        neg_q    <= neg_in;
      end else if (state_q == CALC) begin
        cnt_q    <= cnt_q + CW'(1);
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_sum;
      end
      if (finish) begin
        product_q  <= trunc;
        overflow_q <= ovf;
      end
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq_mul_hs.sv
// Directed bench for seq_mul_hs across unsigned/signed and truncating configurations.
module tb_seq_mul_hs;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  sel;
  logic        drv_valid, drv_ready;
  logic [7:0]  drv_a, drv_b;
  logic        obs_in_ready, obs_out_valid, obs_ov, obs_busy;
  logic [15:0] obs_p;
  int n_vec = 0;
  int n_err = 0;

  // 0: 3x3->4 unsigned, 1: 8x8->16 unsigned, 2: 3x3->6 signed, 3: 3x3->4 signed
  seq_mul_hs_if #(.A_W(3), .B_W(3), .P_W(4))  if0 ();
  seq_mul_hs_if #(.A_W(8), .B_W(8), .P_W(16)) if1 ();
  seq_mul_hs_if #(.A_W(3), .B_W(3), .P_W(6))  if2 ();
  seq_mul_hs_if #(.A_W(3), .B_W(3), .P_W(4))  if3 ();

  seq_mul_hs #(.A_W(3), .B_W(3), .P_W(4),  .SIGNED(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  seq_mul_hs #(.A_W(8), .B_W(8), .P_W(16), .SIGNED(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  seq_mul_hs #(.A_W(3), .B_W(3), .P_W(6),  .SIGNED(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  seq_mul_hs #(.A_W(3), .B_W(3), .P_W(4),  .SIGNED(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  assign if0.in_valid = drv_valid && (sel == 2'd0);
  assign if1.in_valid = drv_valid && (sel == 2'd1);
  assign if2.in_valid = drv_valid && (sel == 2'd2);
  assign if3.in_valid = drv_valid && (sel == 2'd3);
  assign if0.out_ready = drv_ready && (sel == 2'd0);
  assign if1.out_ready = drv_ready && (sel == 2'd1);
  assign if2.out_ready = drv_ready && (sel == 2'd2);
  assign if3.out_ready = drv_ready && (sel == 2'd3);
  assign if0.a = drv_a[2:0];
  assign if0.b = drv_b[2:0];
  assign if1.a = drv_a;
  assign if1.b = drv_b;
  assign if2.a = drv_a[2:0];
  assign if2.b = drv_b[2:0];
  assign if3.a = drv_a[2:0];
  assign if3.b = drv_b[2:0];

  always_comb begin
    obs_in_ready = 1'b0; obs_out_valid = 1'b0; obs_p = '0; obs_ov = 1'b0; obs_busy = 1'b0;
    case (sel)
      2'd0: begin obs_in_ready = if0.in_ready; obs_out_valid = if0.out_valid; obs_p = 16'(if0.product); obs_ov = if0.overflow; obs_busy = if0.busy; end
      2'd1: begin obs_in_ready = if1.in_ready; obs_out_valid = if1.out_valid; obs_p = if1.product;      obs_ov = if1.overflow; obs_busy = if1.busy; end
      2'd2: begin obs_in_ready = if2.in_ready; obs_out_valid = if2.out_valid; obs_p = 16'(if2.product); obs_ov = if2.overflow; obs_busy = if2.busy; end
      default: begin obs_in_ready = if3.in_ready; obs_out_valid = if3.out_valid; obs_p = 16'(if3.product); obs_ov = if3.overflow; obs_busy = if3.busy; end
    endcase
  end

  task automatic test_reset();
    sel = 2'd1; drv_valid = 1'b1; drv_ready = 1'b0; drv_a = 8'd3; drv_b = 8'd4;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (obs_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", obs_in_ready); end
    n_vec++; if (obs_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", obs_out_valid); end
    n_vec++; if (obs_p !== 16'd0) begin n_err++; $display("FAIL reset_product got=%0d exp=0", obs_p); end
    n_vec++; if (obs_ov !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", obs_ov); end
    n_vec++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", obs_busy); end
    rst_n = 1'b1;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL reset_ignore_valid busy got=%b exp=0", obs_busy); end
  endtask

  // One full transaction: accept, latency, result, optional backpressure, output handshake
  task automatic run_op(input logic [1:0] s, input logic [7:0] av, input logic [7:0] bv, input int lat,
                        input logic [15:0] ep, input logic eo, input int hold, input string name);
    int cyc;
    bit got;
    sel = s; drv_ready = 1'b0; drv_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (obs_in_ready) begin got = 1'b1; break; end
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL %s in_ready timeout", name); return; end
    drv_a = av; drv_b = bv; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    n_vec++; if (obs_busy !== 1'b1 || obs_in_ready !== 1'b0)
      begin n_err++; $display("FAIL %s accept busy=%b in_ready=%b exp busy=1 in_ready=0", name, obs_busy, obs_in_ready); end
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (obs_out_valid) begin got = 1'b1; break; end
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL %s out_valid timeout", name); return; end
    n_vec++; if (cyc != lat) begin n_err++; $display("FAIL %s latency got=%0d exp=%0d", name, cyc, lat); end
    n_vec++; if (obs_p !== ep) begin n_err++; $display("FAIL %s product got=0x%0h exp=0x%0h", name, obs_p, ep); end
    n_vec++; if (obs_ov !== eo) begin n_err++; $display("FAIL %s overflow got=%b exp=%b", name, obs_ov, eo); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      drv_valid = ~h[0]; drv_a = ~av; drv_b = ~bv;
      @(posedge clk); #1;
      n_vec++; if (obs_out_valid !== 1'b1 || obs_p !== ep || obs_ov !== eo || obs_in_ready !== 1'b0)
        begin n_err++; $display("FAIL %s hold%0d ov=%b p=0x%0h of=%b rdy=%b exp 1/0x%0h/%b/0", name, h, obs_out_valid, obs_p, obs_ov, obs_in_ready, ep, eo); end
    end
    @(negedge clk);
    drv_valid = 1'b0; drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    n_vec++; if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_busy !== 1'b0)
      begin n_err++; $display("FAIL %s release out_valid=%b in_ready=%b busy=%b exp 0/1/0", name, obs_out_valid, obs_in_ready, obs_busy); end
    n_vec++; if (obs_p !== ep) begin n_err++; $display("FAIL %s product_kept got=0x%0h exp=0x%0h", name, obs_p, ep); end
  endtask

  task automatic test_unsigned_small();
    run_op(2'd0, 8'd7, 8'd2, 3, 16'd14, 1'b0, 0, "u3_7x2");
    run_op(2'd0, 8'd7, 8'd7, 3, 16'd1,  1'b1, 0, "u3_7x7");
    run_op(2'd0, 8'd0, 8'd5, 3, 16'd0,  1'b0, 0, "u3_0x5");
  endtask

  task automatic test_unsigned_wide();
    run_op(2'd1, 8'd255, 8'd255, 8, 16'd65025, 1'b0, 0, "u8_255x255");
    run_op(2'd1, 8'd128, 8'd0,   8, 16'd0,     1'b0, 0, "u8_128x0");
  endtask

  task automatic test_signed();
    run_op(2'd2, 8'd4, 8'd3, 3, 16'h34, 1'b0, 0, "s6_m4x3");
    run_op(2'd2, 8'd4, 8'd4, 3, 16'h10, 1'b0, 0, "s6_m4xm4");
    run_op(2'd2, 8'd3, 8'd3, 3, 16'h09, 1'b0, 0, "s6_3x3");
    run_op(2'd3, 8'd4, 8'd4, 3, 16'h0,  1'b1, 0, "s4_m4xm4");
    run_op(2'd3, 8'd3, 8'd6, 3, 16'hA,  1'b0, 0, "s4_3xm2");
    run_op(2'd3, 8'd0, 8'd7, 3, 16'h0,  1'b0, 0, "s4_0xm1");
  endtask

  task automatic test_backpressure();
    run_op(2'd1, 8'd12, 8'd10, 8, 16'd120, 1'b0, 5, "bp_12x10");
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (obs_out_valid !== 1'b0 || obs_busy !== 1'b0)
      begin n_err++; $display("FAIL bp_single_transfer out_valid=%b busy=%b exp 0/0", obs_out_valid, obs_busy); end
  endtask

  task automatic test_back_to_back();
    int acc_at[$];
    sel = 2'd1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (obs_in_ready) acc_at.push_back(c);
      if (obs_out_valid) begin
        n_vec++; if (obs_p !== 16'd65025) begin n_err++; $display("FAIL b2b_product c=%0d got=%0d exp=65025", c, obs_p); end
      end
      drv_a = 8'd255; drv_b = 8'd255; drv_valid = 1'b1; drv_ready = 1'b1;
    end
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (12) @(negedge clk);
    drv_ready = 1'b0;
    n_vec++;
    if (acc_at.size() < 3) begin n_err++; $display("FAIL b2b_accepts got=%0d exp>=3", acc_at.size()); end
    else begin
      n_vec++; if (acc_at[1] - acc_at[0] != 10) begin n_err++; $display("FAIL b2b_gap0 got=%0d exp=10", acc_at[1] - acc_at[0]); end
      n_vec++; if (acc_at[2] - acc_at[1] != 10) begin n_err++; $display("FAIL b2b_gap1 got=%0d exp=10", acc_at[2] - acc_at[1]); end
    end
  endtask

  task automatic test_reset_mid_calc();
    bit seen;
    sel = 2'd1; drv_ready = 1'b0;
    @(negedge clk);
    drv_a = 8'd100; drv_b = 8'd3; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_p !== 16'd0 || obs_ov !== 1'b0 || obs_busy !== 1'b0)
      begin n_err++; $display("FAIL midreset rdy=%b ov=%b p=%0d of=%b busy=%b exp 1/0/0/0/0", obs_in_ready, obs_out_valid, obs_p, obs_ov, obs_busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (obs_out_valid || obs_busy) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL midreset_no_out_valid got=1 exp=0"); end
    run_op(2'd1, 8'd100, 8'd3, 8, 16'd300, 1'b0, 0, "after_reset_100x3");
  endtask

  initial begin
    sel = 2'd1; drv_valid = 1'b0; drv_ready = 1'b0; drv_a = '0; drv_b = '0; rst_n = 1'b0;
    test_reset();
    test_unsigned_small();
    test_unsigned_wide();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
